ysyx_23060170_shift_seq: RTL and testbench

Multi-cycle shift unit for the NPC execute stage, used as the low-area alternative to the single-cycle barrel shifter. It accepts one shift request (SLL/SRL/SRA, 32-bit operand, 5-bit amount) over a valid/ready handshake. It shifts the operand iteratively by `STEP` bits per cycle and returns the result over a second valid/ready handshake. The request encoding and the result for every legal request are identical to the single-cycle shifter, so the two are interchangeable behind the EXU.

---
 rtl/ysyx_23060170_pkg.sv | 40 ++++
 rtl/ysyx_23060170_shift_step.sv | 23 ++
 rtl/ysyx_23060170_shift_seq.sv | 112 +++++++++++
 tb/tb_ysyx_23060170_shift_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060170_pkg.sv
// Shared NPC definitions: op bit positions, shifter FSM states and the resolved shift op.
// The single-cycle shifter and the EXU use the same op bit positions.
package ysyx_23060170_pkg;

    localparam int XLEN   = 32;
    localparam int AMT_W  = 5;

    localparam int OP_SLL = 2;
    localparam int OP_SRL = 1;
    localparam int OP_SRA = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_SLL  = 2'd1,
        SH_SRL  = 2'd2,
        SH_SRA  = 2'd3
    } shop_e;

    // Multi-hot selects resolve with priority SLL > SRL > SRA; all-zero selects nothing.
    function automatic shop_e resolve_op(input logic [2:0] op);
        shop_e res;
        if (op[OP_SLL]) begin
            res = SH_SLL;
        end else if (op[OP_SRL]) begin
            res = SH_SRL;
        end else if (op[OP_SRA]) begin
            res = SH_SRA;
        end else begin
            res = SH_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_23060170_shift_step.sv
// One iteration of the multi-cycle shifter: shifts by 0..STEP bits for the resolved op.
// SRA replicates the current bit 31 of the partially shifted value.
module ysyx_23060170_shift_step
    import ysyx_23060170_pkg::*;
(
    input  logic [XLEN-1:0]  i_data,
    input  logic [AMT_W-1:0] i_amt,
    input  shop_e            i_op,
    output logic [XLEN-1:0]  o_data
);

    // Per-op shift of the working value; an unresolved op yields zero.
    always_comb begin
        o_data = {XLEN{1'b0}};
        case (i_op)
            SH_SLL:  o_data = i_data << i_amt;
            SH_SRL:  o_data = i_data >> i_amt;
            SH_SRA:  o_data = $unsigned($signed(i_data) >>> i_amt);
            default: o_data = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/ysyx_23060170_shift_seq.sv
// Multi-cycle SLL/SRL/SRA unit: shifts STEP bits per busy cycle behind two valid/ready handshakes.
// in_ready/out_valid are flops loaded from the next state, so they never depend on inputs combinationally.
module ysyx_23060170_shift_seq
    import ysyx_23060170_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  src,
    input  logic [AMT_W-1:0] amt,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out
);

    localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [AMT_W-1:0] r_rem;
    logic [AMT_W-1:0] w_rem_nxt;
    logic [AMT_W-1:0] w_step_amt;
    logic [XLEN-1:0]  r_data;
    logic [XLEN-1:0]  w_data_nxt;
    logic [XLEN-1:0]  w_step_data;
    shop_e            r_op;
    shop_e            w_op_nxt;
    shop_e            w_op_res;
    logic             r_in_ready;
    logic             r_out_valid;

    assign w_op_res   = resolve_op(op);
    assign w_step_amt = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;

    ysyx_23060170_shift_step u_step (
        .i_data (r_data),
        .i_amt  (w_step_amt),
        .i_op   (r_op),
        .o_data (w_step_data)
    );

    // Next-state, remaining count and working data; flush beats accept and handoff.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_data_nxt  = r_data;
        w_op_nxt    = r_op;
        if (flush) begin
            w_state_nxt = IDLE;
            w_rem_nxt   = {AMT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // An all-zero op is loaded as zero so every step keeps it zero.
                        w_data_nxt  = (w_op_res == SH_NONE) ? {XLEN{1'b0}} : src;
                        w_rem_nxt   = amt;
                        w_op_nxt    = w_op_res;
                        w_state_nxt = (amt == {AMT_W{1'b0}}) ? DONE : BUSY;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                BUSY: begin
                    w_data_nxt  = w_step_data;
                    w_rem_nxt   = r_rem - w_step_amt;
                    w_state_nxt = (w_rem_nxt == {AMT_W{1'b0}}) ? DONE : BUSY;
                end
                DONE: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_rem_nxt   = {AMT_W{1'b0}};
                end
            endcase
        end
    end

    // State, datapath and handshake flags; async reset discards any in-flight request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rem       <= {AMT_W{1'b0}};
            r_data      <= {XLEN{1'b0}};
            r_op        <= SH_NONE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_data      <= w_data_nxt;
            r_op        <= w_op_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_data;

endmodule

// File: tb/tb_ysyx_23060170_shift_seq.sv
// Self-checking bench: three instances (STEP = 1, 4, 16) share stimulus; only the addressed one sees in_valid.
// Results and latencies are checked against a full-width reference shift and ceil(amt/STEP).
module tb_ysyx_23060170_shift_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] src = 32'h0;
    logic [4:0]  amt = 5'd0;
    logic [2:0]  op = 3'b000;
    logic        out_ready = 1'b0;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [31:0] out_data  [3];

    int checks = 0;
    int errors = 0;
    int steps [3] = '{1, 4, 16};

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ysyx_23060170_shift_seq #(.STEP(1 << (2 * g))) u_dut (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .src       (src),
            .amt       (amt),
            .op        (op),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out       (out_data[g])
        );
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] s, input logic [4:0] a, input logic [2:0] o);
        if (o[2]) return s << a;
        if (o[1]) return s >> a;
        if (o[0]) return s[31] ? ~((~s) >> a) : (s >> a);
        return 32'h0;
    endfunction

    function automatic int ref_lat(input int idx, input logic [4:0] a);
        return (int'(a) + steps[idx] - 1) / steps[idx];
    endfunction

    // Issues one request at a negedge and waits (bounded) for out_valid; lat = -1 on timeout.
    task automatic run_req(input int idx, input logic [31:0] s, input logic [4:0] a, input logic [2:0] o,
                           output logic [31:0] res, output int lat, output bit ready_low);
        src = s; amt = a; op = o; in_valid[idx] = 1'b1;
        @(negedge clock);
        in_valid[idx] = 1'b0;
        src = $urandom; amt = 5'($urandom); op = 3'($urandom);
        lat = -1; ready_low = 1'b1; res = 32'h0;
        for (int j = 0; j < 64; j++) begin
            if (in_ready[idx] !== 1'b0) ready_low = 1'b0;
            if (out_valid[idx] === 1'b1) begin
                lat = j; res = out_data[idx];
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic handoff(input int stalls);
        out_ready = 1'b0;
        repeat (stalls) @(negedge clock);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || out_data[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset idx=%0d: in_ready=%b out_valid=%b out=%h, expected 1 0 00000000", i, in_ready[i], out_valid[i], out_data[i]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed(input int idx);
        logic [31:0] cs [8] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000001, 32'h80000001, 32'h12345678, 32'hFFFFFFFF};
        logic [4:0]  ca [8] = '{5'd31, 5'd4, 5'd31, 5'd31, 5'd4, 5'd4, 5'd5, 5'd16};
        logic [2:0]  co [8] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b111, 3'b011, 3'b000, 3'b001};
        logic [31:0] ce [8] = '{32'h80000000, 32'hF8000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000010, 32'h08000000, 32'h00000000, 32'hFFFFFFFF};
        logic [31:0] res; int lat; bit rl;
        for (int c = 0; c < 8; c++) begin
            run_req(idx, cs[c], ca[c], co[c], res, lat, rl);
            checks++;
            if (res !== ce[c] || lat != ref_lat(idx, ca[c]) || !rl) begin
                errors++;
                $display("FAIL directed idx=%0d case=%0d: out=%h lat=%0d ready_low=%0b, expected out=%h lat=%0d ready_low=1", idx, c, res, lat, rl, ce[c], ref_lat(idx, ca[c]));
            end
            handoff(c % 3);
        end
    endtask

    task automatic test_zero_amount(input int idx);
        logic [2:0] ops [3] = '{3'b100, 3'b010, 3'b001};
        logic [31:0] res; int lat; bit rl;
        for (int c = 0; c < 3; c++) begin
            run_req(idx, 32'hDEADBEEF, 5'd0, ops[c], res, lat, rl);
            checks++;
            if (res !== 32'hDEADBEEF || lat != 0) begin
                errors++;
                $display("FAIL zero_amount idx=%0d op=%b: out=%h lat=%0d, expected DEADBEEF lat=0", idx, ops[c], res, lat);
            end
            handoff(0);
        end
    endtask

    task automatic test_backpressure(input int idx);
        logic [31:0] res, s2, res2; int lat; bit rl;
        logic [4:0] a2;
        run_req(idx, 32'hC0FFEE11, 5'd13, 3'b001, res, lat, rl);
        checks++;
        if (res !== ref_shift(32'hC0FFEE11, 5'd13, 3'b001) || lat != ref_lat(idx, 5'd13)) begin
            errors++;
            $display("FAIL backpressure_result idx=%0d: out=%h lat=%0d, expected %h lat=%0d", idx, res, lat, ref_shift(32'hC0FFEE11, 5'd13, 3'b001), ref_lat(idx, 5'd13));
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (out_valid[idx] !== 1'b1 || out_data[idx] !== res || in_ready[idx] !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold idx=%0d cyc=%0d: out_valid=%b out=%h in_ready=%b, expected 1 %h 0", idx, c, out_valid[idx], out_data[idx], in_ready[idx], res);
            end
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checks++;
        if (in_ready[idx] !== 1'b1 || out_valid[idx] !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release idx=%0d: in_ready=%b out_valid=%b, expected 1 0", idx, in_ready[idx], out_valid[idx]);
        end
        s2 = $urandom; a2 = 5'($urandom_range(1, 31));
        run_req(idx, s2, a2, 3'b010, res2, lat, rl);
        checks++;
        if (res2 !== ref_shift(s2, a2, 3'b010) || lat != ref_lat(idx, a2)) begin
            errors++;
            $display("FAIL back_to_back idx=%0d: out=%h lat=%0d, expected %h lat=%0d", idx, res2, lat, ref_shift(s2, a2, 3'b010), ref_lat(idx, a2));
        end
        handoff(0);
    endtask

    task automatic test_flush(input int idx);
        bit seen;
        src = 32'h1; amt = 5'd31; op = 3'b100; in_valid[idx] = 1'b1;
        @(negedge clock);
        in_valid[idx] = 1'b0;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++;
        if (in_ready[idx] !== 1'b1 || out_valid[idx] !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy idx=%0d: in_ready=%b out_valid=%b, expected 1 0", idx, in_ready[idx], out_valid[idx]);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid[idx] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_valid idx=%0d: out_valid=1 seen after flush, expected none", idx);
        end
        in_valid[idx] = 1'b1; flush = 1'b1; amt = 5'd31;
        @(negedge clock);
        in_valid[idx] = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL flush_vs_accept idx=%0d: in_ready=%b, expected 1 (request dropped)", idx, in_ready[idx]);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid[idx] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_accept_no_valid idx=%0d: out_valid=1 seen, expected none", idx);
        end
    endtask

    task automatic test_async_reset(input int idx);
        logic [31:0] res; int lat; bit rl; bit seen;
        src = 32'hA5A5A5A5; amt = 5'd31; op = 3'b001; in_valid[idx] = 1'b1;
        @(negedge clock);
        in_valid[idx] = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (in_ready[idx] !== 1'b1 || out_valid[idx] !== 1'b0 || out_data[idx] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset idx=%0d: in_ready=%b out_valid=%b out=%h, expected 1 0 00000000", idx, in_ready[idx], out_valid[idx], out_data[idx]);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (out_valid[idx] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL async_reset_no_valid idx=%0d: out_valid=1 seen after reset, expected none", idx);
        end
        run_req(idx, 32'h0F0F1234, 5'd9, 3'b100, res, lat, rl);
        checks++;
        if (res !== ref_shift(32'h0F0F1234, 5'd9, 3'b100) || lat != ref_lat(idx, 5'd9)) begin
            errors++;
            $display("FAIL async_reset_recover idx=%0d: out=%h lat=%0d, expected %h lat=%0d", idx, res, lat, ref_shift(32'h0F0F1234, 5'd9, 3'b100), ref_lat(idx, 5'd9));
        end
        handoff(1);
    endtask

    task automatic test_random(input int idx, input int n);
        logic [2:0] onehot [3] = '{3'b100, 3'b010, 3'b001};
        logic [31:0] s, res; logic [4:0] a; logic [2:0] o; int lat; bit rl;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            s = $urandom; a = 5'($urandom_range(0, 31));
            o = ($urandom_range(0, 9) == 0) ? 3'($urandom) : onehot[$urandom_range(0, 2)];
            run_req(idx, s, a, o, res, lat, rl);
            checks++;
            if (res !== ref_shift(s, a, o) || lat != ref_lat(idx, a) || !rl) begin
                errors++;
                $display("FAIL random idx=%0d src=%h amt=%0d op=%b: out=%h lat=%0d ready_low=%0b, expected %h lat=%0d", idx, s, a, o, res, lat, rl, ref_shift(s, a, o), ref_lat(idx, a));
            end
            handoff($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        for (int idx = 0; idx < 3; idx++) begin
            test_directed(idx);
            test_zero_amount(idx);
            test_backpressure(idx);
            test_flush(idx);
            test_async_reset(idx);
            test_random(idx, 400);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
